// File: rtl/arty_io_ctrl_if.sv
// CSR access bundle shared with the core CSR file: request fields from the core,
// combinational read data back from the peripheral.
interface arty_io_ctrl_if;
    logic        csr_enable;
    logic [11:0] csr_addr;
    logic [2:0]  csr_op;
    logic [4:0]  rs1_zimm;
    logic [31:0] rs1_data;
    logic [31:0] csr_data_out;

    modport master (
        output csr_enable, csr_addr, csr_op, rs1_zimm, rs1_data,
        input  csr_data_out
    );

    modport slave (
        input  csr_enable, csr_addr, csr_op, rs1_zimm, rs1_data,
        output csr_data_out
    );
endinterface

// File: rtl/arty_io_ctrl.sv
// Arty board I/O behind three CSRs: LED drive, debounced buttons with sticky press
// events (interrupt source), debounced switches with a sticky change flag.
module arty_io_ctrl #(
    parameter int unsigned DebounceCycles = 20000
) (
    input  logic              clk,
    input  logic              reset,
    arty_io_ctrl_if.slave     csr,
    input  logic [3:0]        btn_i,
    input  logic [3:0]        sw_i,
    output logic [3:0]        led_o,
    output logic              irq_o
);
    localparam int unsigned CntWidth = $clog2(DebounceCycles);
    localparam logic [CntWidth-1:0] CntMax = CntWidth'(DebounceCycles - 1);

    typedef enum logic [2:0] {
        OpRW  = 3'b001,
        OpRS  = 3'b010,
        OpRC  = 3'b011,
        OpRWI = 3'b101,
        OpRSI = 3'b110,
        OpRCI = 3'b111
    } csr_op_e;

    typedef enum logic [11:0] {
        AddrLed = 12'h000,
        AddrBtn = 12'h001,
        AddrSw  = 12'h002
    } csr_addr_e;

    logic [7:0]               sync1_q, sync2_q;
    logic [7:0]               stable_q, stable_d;
    logic [7:0][CntWidth-1:0] cnt_q, cnt_d;
    logic [3:0]               led_q, led_d;
    logic [3:0]               btn_evt_q, btn_evt_d;
    logic                     sw_chg_q, sw_chg_d;

    logic [31:0] operand, old_val, new_val;
    logic        mapped, legal_op, wr_en;
    logic [23:0] unused_new_hi;

    // Bits [3:0] are buttons, [7:4] switches; each bit has its own stability counter.
    always_comb begin
        stable_d = stable_q;
        for (int unsigned i = 0; i < 8; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        operand  = csr.csr_op[2] ? {27'b0, csr.rs1_zimm} : csr.rs1_data;
        mapped   = 1'b1;
        old_val  = '0;
        case (csr.csr_addr)
            AddrLed: old_val = {28'b0, led_q};
            AddrBtn: old_val = {24'b0, btn_evt_q, stable_q[3:0]};
            AddrSw:  old_val = {27'b0, sw_chg_q, stable_q[7:4]};
            default: mapped  = 1'b0;
        endcase

        legal_op = 1'b1;
        new_val  = operand;
        case (csr.csr_op)
            OpRW, OpRWI: new_val  = operand;
            OpRS, OpRSI: new_val  = old_val | operand;
            OpRC, OpRCI: new_val  = old_val & ~operand;
            default:     legal_op = 1'b0;
        endcase
        wr_en = csr.csr_enable && mapped && legal_op;
    end

    assign csr.csr_data_out = old_val;
    assign unused_new_hi    = new_val[31:8];

    always_comb begin
        led_d     = led_q;
        btn_evt_d = btn_evt_q;
        sw_chg_d  = sw_chg_q;
        if (wr_en) begin
            case (csr.csr_addr)
                AddrLed: led_d     = new_val[3:0];
                AddrBtn: btn_evt_d = btn_evt_q & new_val[7:4];
                AddrSw:  sw_chg_d  = sw_chg_q & new_val[4];
                default: ;
            endcase
        end
        // Hardware sets are applied after the software clear so a same-cycle edge is kept.
        btn_evt_d = btn_evt_d | (stable_d[3:0] & ~stable_q[3:0]);
        if (stable_d[7:4] != stable_q[7:4]) begin
            sw_chg_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            stable_q  <= '0;
            cnt_q     <= '0;
            led_q     <= '0;
            btn_evt_q <= '0;
            sw_chg_q  <= 1'b0;
        end else begin
            sync1_q   <= {sw_i, btn_i};
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            cnt_q     <= cnt_d;
            led_q     <= led_d;
            btn_evt_q <= btn_evt_d;
            sw_chg_q  <= sw_chg_d;
        end
    end

    assign led_o = led_q;
    assign irq_o = |btn_evt_q;
endmodule

// File: tb/tb_arty_io_ctrl.sv
// Bench for arty_io_ctrl with a short debounce window: directed CSR table, hand-written
// debounce/event sequences, then random pins and CSR traffic against a reference model.
module tb_arty_io_ctrl;
    localparam int unsigned D = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn_i, sw_i, led_o;
    logic       irq_o;

    arty_io_ctrl_if bus();

    arty_io_ctrl #(.DebounceCycles(D)) dut (
        .clk   (clk),
        .reset (reset),
        .csr   (bus.slave),
        .btn_i (btn_i),
        .sw_i  (sw_i),
        .led_o (led_o),
        .irq_o (irq_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a pin is accepted once the last D synchronised samples all disagree
    // with the accepted level; synchroniser is a plain two-sample delay.
    logic [7:0] m_p1, m_p2, m_stable;
    logic [7:0] m_hist[$];
    logic [3:0] m_led, m_evt;
    logic       m_chg;

    function automatic void model_reset();
        m_p1 = '0; m_p2 = '0; m_stable = '0;
        m_hist.delete();
        m_led = '0; m_evt = '0; m_chg = 1'b0;
    endfunction

    function automatic logic [31:0] model_read();
        case (bus.csr_addr)
            12'h000: return {28'b0, m_led};
            12'h001: return {24'b0, m_evt, m_stable[3:0]};
            12'h002: return {27'b0, m_chg, m_stable[7:4]};
            default: return 32'h0;
        endcase
    endfunction

    function automatic void model_step();
        logic [7:0]  s, ns;
        logic [31:0] opnd, oldv, newv;
        bit          wr;
        int          disagree;
        s  = m_p2;
        ns = m_stable;
        m_p2 = m_p1;
        m_p1 = {sw_i, btn_i};
        m_hist.push_back(s);
        if (m_hist.size() > D) void'(m_hist.pop_front());
        for (int i = 0; i < 8; i++) begin
            disagree = 0;
            foreach (m_hist[k]) if (m_hist[k][i] != m_stable[i]) disagree++;
            if (m_hist.size() == D && disagree == D) ns[i] = ~m_stable[i];
        end

        oldv = model_read();
        opnd = bus.csr_op[2] ? {27'b0, bus.rs1_zimm} : bus.rs1_data;
        wr   = bus.csr_enable && (bus.csr_addr <= 12'd2) && bus.csr_op != 3'b000 && bus.csr_op != 3'b100;
        case (bus.csr_op[1:0])
            2'b01:   newv = opnd;
            2'b10:   newv = oldv | opnd;
            default: newv = oldv & ~opnd;
        endcase
        if (wr) begin
            case (bus.csr_addr)
                12'h000: m_led = newv[3:0];
                12'h001: m_evt = m_evt & newv[7:4];
                12'h002: m_chg = m_chg & newv[4];
                default: ;
            endcase
        end
        m_evt = m_evt | (ns[3:0] & ~m_stable[3:0]);
        if (ns[7:4] != m_stable[7:4]) m_chg = 1'b1;
        m_stable = ns;
    endfunction

    task automatic tick();
        #1;
        if (reset) model_reset();
        check("rd_model", bus.csr_data_out, model_read());
        @(posedge clk);
        if (reset) model_reset();
        else model_step();
        #1;
        check("led_model", {28'b0, led_o}, {28'b0, m_led});
        check("irq_model", {31'b0, irq_o}, {31'b0, |m_evt});
        @(negedge clk);
    endtask

    task automatic csr_set(input logic en, input logic [11:0] addr, input logic [2:0] op,
                           input logic [4:0] zimm, input logic [31:0] rs1);
        bus.csr_enable = en;
        bus.csr_addr   = addr;
        bus.csr_op     = op;
        bus.rs1_zimm   = zimm;
        bus.rs1_data   = rs1;
    endtask

    typedef struct {
        logic        en;
        logic [11:0] addr;
        logic [2:0]  op;
        logic [4:0]  zimm;
        logic [31:0] rs1;
        logic [31:0] exp_rd;
        logic [3:0]  exp_led;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{1'b1, 12'h000, 3'b101, 5'd5,  32'h0,        32'h0, 4'h5};
        vecs[1]  = '{1'b1, 12'h000, 3'b110, 5'd2,  32'h0,        32'h5, 4'h7};
        vecs[2]  = '{1'b1, 12'h000, 3'b011, 5'd0,  32'h1,        32'h7, 4'h6};
        vecs[3]  = '{1'b1, 12'h000, 3'b000, 5'd0,  32'hF,        32'h6, 4'h6};
        vecs[4]  = '{1'b1, 12'h000, 3'b100, 5'hF,  32'hF,        32'h6, 4'h6};
        vecs[5]  = '{1'b1, 12'h003, 3'b001, 5'd0,  32'hFFFFFFFF, 32'h0, 4'h6};
        vecs[6]  = '{1'b1, 12'h000, 3'b010, 5'd0,  32'h8,        32'h6, 4'hE};
        vecs[7]  = '{1'b0, 12'h000, 3'b001, 5'd0,  32'h3,        32'hE, 4'hE};
        vecs[8]  = '{1'b1, 12'h000, 3'b111, 5'h1F, 32'h0,        32'hE, 4'h0};
        vecs[9]  = '{1'b1, 12'h000, 3'b001, 5'd0,  32'hFFFFFFF9, 32'h0, 4'h9};
        vecs[10] = '{1'b1, 12'h002, 3'b001, 5'd0,  32'hFFFFFFFF, 32'h0, 4'h9};
        vecs[11] = '{1'b1, 12'h001, 3'b001, 5'd0,  32'h000000FF, 32'h0, 4'h9};

        // Reset held with all buttons pressed
        reset = 1'b1; btn_i = 4'hF; sw_i = 4'h0;
        csr_set(1'b0, 12'h000, 3'b000, 5'd0, 32'h0);
        model_reset();
        for (int a = 0; a < 3; a++) begin
            bus.csr_addr = 12'(a);
            #1 check("rst_rd", bus.csr_data_out, 32'h0);
        end
        check("rst_led", {28'b0, led_o}, 32'h0);
        check("rst_irq", {31'b0, irq_o}, 32'h0);
        tick(); tick();
        check("rst_held_irq", {31'b0, irq_o}, 32'h0);
        reset = 1'b0; btn_i = 4'h0;
        repeat (3) tick();

        // CSR op table on the LED / unmapped / read-only locations
        foreach (vecs[i]) begin
            csr_set(vecs[i].en, vecs[i].addr, vecs[i].op, vecs[i].zimm, vecs[i].rs1);
            #1 check("tbl_rd", bus.csr_data_out, vecs[i].exp_rd);
            tick();
            check("tbl_led", {28'b0, led_o}, {28'b0, vecs[i].exp_led});
        end

        // Press latency: pin to stable/event in 2+D cycles
        csr_set(1'b0, 12'h001, 3'b000, 5'd0, 32'h0);
        btn_i = 4'h1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check("press_lat", bus.csr_data_out, (k == 6) ? 32'h11 : 32'h0);
        end
        check("press_irq", {31'b0, irq_o}, 32'h1);

        // Software clear of the press event
        csr_set(1'b1, 12'h001, 3'b011, 5'd0, 32'h10);
        tick();
        csr_set(1'b0, 12'h001, 3'b000, 5'd0, 32'h0);
        #1 check("clr_evt", bus.csr_data_out, 32'h01);
        check("clr_irq", {31'b0, irq_o}, 32'h0);

        // Glitch shorter than the debounce window
        btn_i = 4'h3;
        repeat (3) tick();
        btn_i = 4'h1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("glitch_rd", bus.csr_data_out, 32'h01);
            check("glitch_irq", {31'b0, irq_o}, 32'h0);
        end

        // Release, then clear in the very cycle a new press is accepted
        btn_i = 4'h0;
        repeat (8) tick();
        check("release_rd", bus.csr_data_out, 32'h00);
        btn_i = 4'h1;
        repeat (5) tick();
        csr_set(1'b1, 12'h001, 3'b011, 5'd0, 32'h10);
        tick();
        csr_set(1'b0, 12'h001, 3'b000, 5'd0, 32'h0);
        #1 check("clr_vs_set", bus.csr_data_out, 32'h11);
        check("clr_vs_set_irq", {31'b0, irq_o}, 32'h1);
        csr_set(1'b1, 12'h001, 3'b011, 5'd0, 32'h10);
        tick();
        csr_set(1'b0, 12'h001, 3'b000, 5'd0, 32'h0);

        // Switch change flag, its clear, and an unmapped write
        csr_set(1'b0, 12'h002, 3'b000, 5'd0, 32'h0);
        sw_i = 4'h4;
        repeat (6) tick();
        check("sw_chg", bus.csr_data_out, 32'h14);
        csr_set(1'b1, 12'h002, 3'b001, 5'd0, 32'h0);
        tick();
        csr_set(1'b0, 12'h002, 3'b000, 5'd0, 32'h0);
        #1 check("sw_clr", bus.csr_data_out, 32'h04);
        csr_set(1'b1, 12'h003, 3'b001, 5'd0, 32'hFFFFFFFF);
        #1 check("unmapped_rd", bus.csr_data_out, 32'h0);
        tick();
        csr_set(1'b0, 12'h000, 3'b000, 5'd0, 32'h0);
        #1 check("post_unmapped_led", bus.csr_data_out, 32'h09);
        bus.csr_addr = 12'h001;
        #1 check("post_unmapped_btn", bus.csr_data_out, 32'h01);
        bus.csr_addr = 12'h002;
        #1 check("post_unmapped_sw", bus.csr_data_out, 32'h04);

        // Reset in the middle of a debounce, pins still held afterwards
        bus.csr_addr = 12'h001;
        btn_i = 4'h9;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check("rst_mid_rd", bus.csr_data_out, 32'h0);
        reset = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check("rst_mid_relatch", bus.csr_data_out, (k == 6) ? 32'h99 : 32'h0);
        end

        // Random pins and CSR traffic against the model
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 299) == 0);
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 9) == 0) btn_i[b] = ~btn_i[b];
                if ($urandom_range(0, 9) == 0) sw_i[b] = ~sw_i[b];
            end
            csr_set(1'($urandom_range(0, 1)), 12'($urandom_range(0, 3)),
                    3'($urandom_range(0, 7)), 5'($urandom), $urandom);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
